// File: rtl/calc_pkg.sv
// Shared definitions for the calculator control unit.
//   state_t      : FSM state encoding (3 bits; codes 5-7 are illegal)
//   MUX_*        : register-file write-data mux select codes (s1)
//   OP_*         : ALU opcode constants in the un-inverted encoding
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [1:0] MUX_IN1 = 2'b11;
    localparam logic [1:0] MUX_IN2 = 2'b10;
    localparam logic [1:0] MUX_ALU = 2'b00;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/calc_cu_seq.sv
// Control unit for the calculator datapath (register file + ALU + muxes).
// On go it loads operand A and operand B into the register file, runs the ALU
// one or more passes (repeat mode), writes the result back and signals done.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   go                  : start request (level), accepted in IDLE, released in DONE
//   abort               : synchronous abort, returns to IDLE from any state
//   op, repeat_en, iters: operation, repeat mode and pass count, latched on accept
//   we, wa              : RF write enable / address
//   rea, reb, raa, rab  : RF read enables / addresses
//   s1                  : RF write-data mux select (MUX_IN1/MUX_IN2/MUX_ALU)
//   s2                  : display mux, 1 = ALU result
//   alu_ctrl            : ALU control (optionally inverted op)
//   busy, done_calc, cs : status and current state
//
// Handshake: go is a level request. It is sampled only in IDLE; once accepted
// the operation always completes (unless aborted), and DONE is held until go
// is seen low, so a held button never auto-restarts a second operation.
module calc_cu_seq
    import calc_pkg::*;
#(
    parameter int ADDR_W  = 2,
    parameter int OP_W    = 2,
    parameter int ITER_W  = 4,
    parameter int A_ADDR  = 1,
    parameter int B_ADDR  = 2,
    parameter int R_ADDR  = 3,
    parameter bit ALU_INV = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              abort,
    input  logic [OP_W-1:0]   op,
    input  logic              repeat_en,
    input  logic [ITER_W-1:0] iters,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic              rea,
    output logic              reb,
    output logic [ADDR_W-1:0] raa,
    output logic [ADDR_W-1:0] rab,
    output logic [1:0]        s1,
    output logic              s2,
    output logic [OP_W-1:0]   alu_ctrl,
    output logic              busy,
    output logic              done_calc,
    output logic [2:0]        cs
);

    localparam logic [ADDR_W-1:0] A_A = ADDR_W'(A_ADDR);
    localparam logic [ADDR_W-1:0] B_A = ADDR_W'(B_ADDR);
    localparam logic [ADDR_W-1:0] R_A = ADDR_W'(R_ADDR);

    state_t              state_q, state_d;
    logic [ITER_W-1:0]   cnt_q, cnt_d;
    // Holds the op already converted to the ALU's encoding; repeat_en is folded
    // into the pass count at acceptance, so it needs no register of its own.
    logic [OP_W-1:0]     alu_q, alu_d;

    logic                we_q, we_d;
    logic [ADDR_W-1:0]   wa_q, wa_d;
    logic                rea_q, rea_d;
    logic                reb_q, reb_d;
    logic [ADDR_W-1:0]   raa_q, raa_d;
    logic [ADDR_W-1:0]   rab_q, rab_d;
    logic [1:0]          s1_q, s1_d;
    logic                s2_q, s2_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Next state and latched registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        alu_d   = alu_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        state_d = LOAD_A;
                        alu_d   = ALU_INV ? ~op : op;
                        cnt_d   = (repeat_en && (iters != '0)) ? iters : ITER_W'(1);
                    end
                end
                LOAD_A: state_d = LOAD_B;
                LOAD_B: state_d = EXEC;
                EXEC: begin
                    cnt_d = cnt_q - ITER_W'(1);
                    // <= 1 rather than == 1 so a corrupted zero count cannot
                    // trap the FSM in a long wrap-around loop.
                    if (cnt_q <= ITER_W'(1)) state_d = DONE;
                end
                DONE: begin
                    if (!go) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so each output
    // register holds the Moore value of the state it will be in.
    always_comb begin
        we_d   = 1'b0;
        wa_d   = '0;
        rea_d  = 1'b0;
        reb_d  = 1'b0;
        raa_d  = '0;
        rab_d  = '0;
        s1_d   = MUX_ALU;
        s2_d   = 1'b0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        case (state_d)
            LOAD_A: begin
                we_d = 1'b1;
                wa_d = A_A;
                s1_d = MUX_IN1;
            end
            LOAD_B: begin
                we_d = 1'b1;
                wa_d = B_A;
                s1_d = MUX_IN2;
            end
            EXEC: begin
                rea_d = 1'b1;
                reb_d = 1'b1;
                // First pass reads A; later passes accumulate on the result.
                raa_d = (state_q == LOAD_B) ? A_A : R_A;
                rab_d = B_A;
                we_d  = 1'b1;
                wa_d  = R_A;
                s1_d  = MUX_ALU;
                s2_d  = 1'b1;
            end
            DONE: begin
                rea_d = 1'b1;
                reb_d = 1'b1;
                raa_d = R_A;
                rab_d = B_A;
                s2_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            alu_q   <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            rea_q   <= 1'b0;
            reb_q   <= 1'b0;
            raa_q   <= '0;
            rab_q   <= '0;
            s1_q    <= MUX_ALU;
            s2_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alu_q   <= alu_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            rea_q   <= rea_d;
            reb_q   <= reb_d;
            raa_q   <= raa_d;
            rab_q   <= rab_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // abort suppresses the write of the cycle in which it is raised, so an
    // aborted operation never lands a partial value in the register file.
    assign we        = we_q & ~abort;
    assign wa        = wa_q;
    assign rea       = rea_q;
    assign reb       = reb_q;
    assign raa       = raa_q;
    assign rab       = rab_q;
    assign s1        = s1_q;
    assign s2        = s2_q;
    assign alu_ctrl  = alu_q;
    assign busy      = busy_q;
    assign done_calc = done_q;
    assign cs        = state_q;

endmodule
